simt_dmem_responder: RTL and testbench



---
 rtl/simt_dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_simt_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simt_dmem_responder
// Data-memory responder for the SIMT core: services each active lane of a
// load/store request against an internal RAM, lowest lane first.
// Rev 1.0
// ----------------------------------------------------------------------------
module simt_dmem_responder #(
  parameter int N_LANES    = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int ACCESS_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        MRead,
  input  logic                        MWrite,
  input  logic [N_LANES-1:0]          lane_mask,
  input  logic [N_LANES*ADDR_W-1:0]   addr_bus,
  input  logic [N_LANES*DATA_W-1:0]   wdata_bus,
  output logic [N_LANES*DATA_W-1:0]   rdata_bus,
  output logic                        MReady,
  output logic                        busy,
  output logic                        req_err
);

  localparam int                CNT_W      = 4;
  localparam int                MEM_DEPTH  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                       state_q;
  logic                         op_wr_q;
  logic [N_LANES*ADDR_W-1:0]    addr_q;
  logic [N_LANES*DATA_W-1:0]    wdata_q;
  logic [N_LANES-1:0]           rem_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [N_LANES*DATA_W-1:0]    rdata_q;
  logic                         mready_q;
  logic                         busy_q;
  logic                         req_err_q;

  logic [DATA_W-1:0]            mem [0:MEM_DEPTH-1];

  logic [N_LANES-1:0]           lane_onehot;
  logic [N_LANES-1:0]           rem_d;
  logic [ADDR_W-1:0]            cur_addr;
  logic [DATA_W-1:0]            cur_wdata;
  logic [DATA_W-1:0]            rd_word;
  logic                         access_fire;
  logic                         req_any;
  logic                         req_one;

  // Two's-complement trick isolates the lowest pending lane as a one-hot.
  assign lane_onehot = rem_q & (~rem_q + N_LANES'(1));
  assign rem_d       = rem_q & ~lane_onehot;
  assign access_fire = (state_q == ACCESS) && (cnt_q == '0);
  assign req_any     = MRead | MWrite;
  assign req_one     = MRead ^ MWrite;

  always_comb begin
    cur_addr  = '0;
    cur_wdata = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_onehot[i]) begin
        cur_addr  = addr_q[i*ADDR_W +: ADDR_W];
        cur_wdata = wdata_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_word = mem[cur_addr];

  // RAM contents survive reset; only the access engine is cleared.
  always_ff @(posedge clk) begin
    if (access_fire && op_wr_q) begin
      mem[cur_addr] <= cur_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mready_q  <= 1'b0;
      busy_q    <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      mready_q  <= 1'b0;
      req_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_one) begin
            op_wr_q <= MWrite;
            addr_q  <= addr_bus;
            wdata_q <= wdata_bus;
            rem_q   <= lane_mask;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
            if (lane_mask == '0) begin
              state_q  <= DONE;
              mready_q <= 1'b1;
            end else begin
              state_q  <= ACCESS;
            end
          end else if (req_any) begin
            req_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (req_any) begin
            req_err_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            if (!op_wr_q) begin
              for (int i = 0; i < N_LANES; i++) begin
                if (lane_onehot[i]) begin
                  rdata_q[i*DATA_W +: DATA_W] <= rd_word;
                end
              end
            end
            rem_q <= rem_d;
            cnt_q <= CNT_RELOAD;
            if (rem_d == '0) begin
              state_q  <= DONE;
              mready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (req_any) begin
            req_err_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata_bus = rdata_q;
  assign MReady    = mready_q;
  assign busy      = busy_q;
  assign req_err   = req_err_q;

endmodule
`default_nettype wire

// File: tb/tb_simt_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_simt_dmem_responder
// Scoreboard bench: a lane-level memory model predicts every completion.
// ----------------------------------------------------------------------------
module tb_simt_dmem_responder;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic        clk;
  logic        reset;
  logic        MRead, MWrite;
  logic [3:0]  lane_mask;
  logic [31:0] addr_bus;
  logic [63:0] wdata_bus;
  logic [63:0] rdata_bus;
  logic        MReady, busy, req_err;

  logic        r3, w3;
  logic [3:0]  m3;
  logic [31:0] a3;
  logic [63:0] d3;
  logic [63:0] rd3;
  logic        rdy3, busy3, err3;

  simt_dmem_responder #(.N_LANES(4), .DATA_W(16), .ADDR_W(8), .ACCESS_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite),
    .lane_mask(lane_mask), .addr_bus(addr_bus), .wdata_bus(wdata_bus),
    .rdata_bus(rdata_bus), .MReady(MReady), .busy(busy), .req_err(req_err)
  );

  simt_dmem_responder #(.N_LANES(4), .DATA_W(16), .ADDR_W(8), .ACCESS_LAT(LAT3)) u_dut3 (
    .clk(clk), .reset(reset), .MRead(r3), .MWrite(w3),
    .lane_mask(m3), .addr_bus(a3), .wdata_bus(d3),
    .rdata_bus(rd3), .MReady(rdy3), .busy(busy3), .req_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [63:0] rd;
  } rdy_t;

  rdy_t        rdy_q[$];
  int          err_q[$];
  logic [15:0] mmem [0:255];
  logic [63:0] model_rd = '0;
  int          free_edge = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  bit          mon_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; the request is captured on the next rising edge.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] m,
                       input logic [31:0] a, input logic [63:0] d);
    int e;
    int k;
    e = cyc + 1;
    MRead = rd; MWrite = wr; lane_mask = m; addr_bus = a; wdata_bus = d;
    if ((rd && wr) || e < free_edge) begin
      err_q.push_back(e);
    end else if (rd || wr) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          k++;
          if (wr) mmem[a[i*8 +: 8]] = d[i*16 +: 16];
          else    model_rd[i*16 +: 16] = mmem[a[i*8 +: 8]];
        end
      end
      rdy_q.push_back('{at: e + k*LAT, rd: model_rd});
      busy_lo   = e;
      busy_hi   = e + k*LAT;
      free_edge = e + k*LAT + 2;
    end
    @(negedge clk);
    MRead = 1'b0; MWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && !reset) begin
      bit exp_r, exp_e, exp_b;
      exp_r = (rdy_q.size() > 0) && (rdy_q[0].at == cyc);
      exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
      exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
      if (MReady || exp_r) begin
        chk("mready", 64'(MReady), 64'(exp_r));
        if (exp_r) begin
          chk("rdata", rdata_bus, rdy_q[0].rd);
          void'(rdy_q.pop_front());
        end
      end
      if (req_err || exp_e) begin
        chk("req_err", 64'(req_err), 64'(exp_e));
        if (exp_e) void'(err_q.pop_front());
      end
      chk("busy", 64'(busy), 64'(exp_b));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset = 1'b1;
    MRead = 1'b0; MWrite = 1'b0; lane_mask = '0; addr_bus = '0; wdata_bus = '0;
    r3 = 1'b0; w3 = 1'b0; m3 = '0; a3 = '0; d3 = '0;
    repeat (3) sample();
    chk("reset_mready", 64'(MReady), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(req_err), 64'd0);
    chk("reset_rdata", rdata_bus, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    mon_en = 1'b1;

    // Preload addresses 0..15 so every later load reads defined data.
    for (int b = 0; b < 4; b++) begin
      logic [31:0] a;
      logic [63:0] d;
      for (int i = 0; i < 4; i++) begin
        a[i*8 +: 8]   = 8'(b*4 + i);
        d[i*16 +: 16] = 16'($urandom);
      end
      issue(1'b0, 1'b1, 4'hF, a, d);
      idle(6);
    end

    issue(1'b0, 1'b1, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, 64'h000D_000C_000B_000A);
    idle(6);
    issue(1'b1, 1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, 64'h0);
    idle(6);
    chk("full_rdata", rdata_bus, 64'h000D_000C_000B_000A);

    issue(1'b0, 1'b1, 4'b1010, {4{8'd7}}, 64'h0044_0033_0022_0011);
    idle(5);
    issue(1'b1, 1'b0, 4'b0001, {4{8'd7}}, 64'h0);
    idle(4);
    chk("partial_rdata", rdata_bus, 64'h000D_000C_000B_0044);

    issue(1'b1, 1'b0, 4'b0000, {4{8'd3}}, 64'h0);
    idle(3);
    chk("empty_rdata", rdata_bus, 64'h000D_000C_000B_0044);

    issue(1'b1, 1'b1, 4'b1111, {4{8'd2}}, {4{16'hBEEF}});
    idle(3);
    issue(1'b1, 1'b0, 4'b1111, {8'd0, 8'd1, 8'd2, 8'd3}, 64'h0);
    issue(1'b1, 1'b0, 4'b1111, {4{8'd5}}, 64'h0);
    idle(8);

    for (int it = 0; it < 400; it++) begin
      int r;
      logic [31:0] a;
      logic [63:0] d;
      r = int'($urandom_range(0, 9));
      for (int i = 0; i < 4; i++) begin
        a[i*8 +: 8]   = 8'($urandom_range(0, 15));
        d[i*16 +: 16] = 16'($urandom);
      end
      if (r < 5)       idle(1);
      else if (r == 5) issue(1'b1, 1'b1, 4'($urandom), a, d);
      else if (r < 8)  issue(1'b1, 1'b0, 4'($urandom), a, d);
      else             issue(1'b0, 1'b1, 4'($urandom), a, d);
    end

    for (int i = 0; i < 200 && (rdy_q.size() > 0 || err_q.size() > 0); i++) @(negedge clk);
    chk("drain_ready", 64'(rdy_q.size()), 64'd0);
    chk("drain_err", 64'(err_q.size()), 64'd0);
    idle(2);

    // Slow-access instance: two lanes at three cycles each.
    @(negedge clk);
    e = cyc + 1;
    w3 = 1'b1; m3 = 4'b0110; a3 = {8'd0, 8'd6, 8'd5, 8'd0}; d3 = 64'h0000_2222_1111_0000;
    @(negedge clk);
    w3 = 1'b0;
    while (cyc < e + 6) sample();
    chk("lat3_store_ready", 64'(rdy3), 64'd1);
    idle(4);
    e = cyc + 1;
    r3 = 1'b1;
    @(negedge clk);
    r3 = 1'b0;
    while (cyc < e + 3) sample();
    chk("lat3_lane1_first", 64'(rd3[31:16]), 64'h1111);
    chk("lat3_lane2_pending", 64'(rd3[47:32]), 64'h0);
    chk("lat3_busy", 64'(busy3), 64'd1);
    while (cyc < e + 5) sample();
    chk("lat3_not_ready", 64'(rdy3), 64'd0);
    sample();
    chk("lat3_ready", 64'(rdy3), 64'd1);
    chk("lat3_rdata", rd3, 64'h0000_2222_1111_0000);
    chk("lat3_no_err", 64'(err3), 64'd0);
    idle(3);

    // Reset in the middle of a load.
    mon_en = 1'b0;
    @(negedge clk);
    MRead = 1'b1; lane_mask = 4'hF; addr_bus = {8'd3, 8'd2, 8'd1, 8'd0};
    @(negedge clk);
    MRead = 1'b0;
    sample();
    chk("busy_before_reset", 64'(busy), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_mready", 64'(MReady), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_err", 64'(req_err), 64'd0);
    chk("midreset_rdata", rdata_bus, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
